// File: rtl/dda_link_pkg.sv
// Shared types and frame-layout constants for the DDA link host.
package dda_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TX_SEND,
    TX_HOLD,
    TX_WAIT,
    RX_WAIT,
    DONE
  } state_e;

  localparam int N_DEFAULT   = 16;
  localparam int FIELD_BYTES = N_DEFAULT / 8;
  localparam int NUM_FIELDS  = 5;
  localparam int TX_BYTES    = 10;
  localparam int RX_BYTES    = 5;

  // Field order inside the request frame.
  localparam int IC1  = 0;
  localparam int IC2  = 1;
  localparam int VK_M = 2;
  localparam int VD_M = 3;
  localparam int DT   = 4;

  localparam int TX_IDX_W = $clog2(TX_BYTES + 1);
  localparam int RX_IDX_W = $clog2(RX_BYTES + 1);

endpackage

// File: rtl/dda_link_timeout.sv
// Inter-byte watchdog: up-counter with clear and enable; expire flags the
// cycle on which the count would reach LIMIT.
module dda_link_timeout #(
  parameter int LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over counting so a received byte restarts the window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire = en && !clr && (cnt_q == CW'(LIMIT - 1));

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dda_link_host.sv
// Host-side initiator: serialises five parameters into a 10-byte request,
// then collects the 5-byte response and presents v1/v2 with a done pulse.
module dda_link_host
  import dda_link_pkg::*;
#(
  parameter int N              = N_DEFAULT,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] ic1,
  input  logic [N-1:0] ic2,
  input  logic [N-1:0] vK_M,
  input  logic [N-1:0] vD_M,
  input  logic [N-1:0] dt,
  output logic         busy,
  output logic         done,
  output logic         err_timeout,
  output logic         err_rx,
  output logic [N-1:0] v1,
  output logic [N-1:0] v2,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  input  logic         tx_busy,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  input  logic         rx_error
);

  localparam int RXB_N = 2 * FIELD_BYTES;
  localparam int RXB_W = $clog2(RXB_N);

  state_e                state_q, state_d;
  logic [7:0]            buf_q [TX_BYTES];
  logic [7:0]            buf_d [TX_BYTES];
  logic [7:0]            rx_buf_q [RXB_N];
  logic [7:0]            rx_buf_d [RXB_N];
  logic [TX_IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [RX_IDX_W-1:0]   rx_idx_q, rx_idx_d;
  logic                  done_q, done_d;
  logic                  err_timeout_q, err_timeout_d;
  logic                  err_rx_q, err_rx_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [N-1:0]          v1_q, v1_d;
  logic [N-1:0]          v2_q, v2_d;
  logic [N-1:0]          fields [NUM_FIELDS];
  logic                  tx_last, rx_last, rx_store;
  logic                  tmr_clr, tmr_en, tmr_expire;

  assign fields[IC1]  = ic1;
  assign fields[IC2]  = ic2;
  assign fields[VK_M] = vK_M;
  assign fields[VD_M] = vD_M;
  assign fields[DT]   = dt;

  assign tx_last  = (byte_idx_q == TX_IDX_W'(TX_BYTES));
  assign rx_last  = (rx_idx_q == RX_IDX_W'(RX_BYTES - 1));
  assign rx_store = (rx_idx_q < RX_IDX_W'(RXB_N));

  // The timer is zeroed while the last byte drains so RX_WAIT starts a fresh
  // window; a byte and an error both stop it from counting that cycle.
  assign tmr_clr = (state_q == TX_WAIT) || ((state_q == RX_WAIT) && rx_valid);
  assign tmr_en  = (state_q == RX_WAIT) && !rx_valid && !rx_error;

  dda_link_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; rx_error outranks a same-cycle byte, a byte outranks expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = TX_SEND;
      TX_SEND: if (!tx_busy) state_d = TX_HOLD;
      TX_HOLD: state_d = TX_WAIT;
      TX_WAIT: if (!tx_busy) state_d = tx_last ? RX_WAIT : TX_SEND;
      RX_WAIT: begin
        if (rx_error) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          if (rx_last) state_d = DONE;
        end else if (tmr_expire) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs for each state.
  always_comb begin
    buf_d         = buf_q;
    rx_buf_d      = rx_buf_q;
    byte_idx_d    = byte_idx_q;
    rx_idx_d      = rx_idx_q;
    done_d        = 1'b0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    err_timeout_d = err_timeout_q;
    err_rx_d      = err_rx_q;
    v1_d          = v1_q;
    v2_d          = v2_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int f = 0; f < NUM_FIELDS; f++) begin
            for (int b = 0; b < FIELD_BYTES; b++) begin
              buf_d[f*FIELD_BYTES + b] = fields[f][N-1-8*b -: 8];
            end
          end
          err_timeout_d = 1'b0;
          err_rx_d      = 1'b0;
          byte_idx_d    = '0;
        end
      end
      TX_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = buf_q[byte_idx_q];
          byte_idx_d = byte_idx_q + 1'b1;
        end
      end
      TX_WAIT: begin
        if (!tx_busy && tx_last) rx_idx_d = '0;
      end
      RX_WAIT: begin
        if (rx_error) begin
          err_rx_d = 1'b1;
        end else if (rx_valid) begin
          if (rx_store) rx_buf_d[rx_idx_q[RXB_W-1:0]] = rx_data;
          rx_idx_d = rx_idx_q + 1'b1;
          if (rx_last) begin
            // The trailer byte arriving now is dropped; b0..b3 are already held.
            for (int b = 0; b < FIELD_BYTES; b++) begin
              v1_d[N-1-8*b -: 8] = rx_buf_q[b];
              v2_d[N-1-8*b -: 8] = rx_buf_q[FIELD_BYTES + b];
            end
            done_d = 1'b1;
          end
        end else if (tmr_expire) begin
          err_timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; all clear asynchronously so tx_start drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TX_BYTES; i++) buf_q[i] <= '0;
      for (int i = 0; i < RXB_N; i++) rx_buf_q[i] <= '0;
      byte_idx_q    <= '0;
      rx_idx_q      <= '0;
      done_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      err_timeout_q <= 1'b0;
      err_rx_q      <= 1'b0;
      v1_q          <= '0;
      v2_q          <= '0;
    end else begin
      buf_q         <= buf_d;
      rx_buf_q      <= rx_buf_d;
      byte_idx_q    <= byte_idx_d;
      rx_idx_q      <= rx_idx_d;
      done_q        <= done_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      err_timeout_q <= err_timeout_d;
      err_rx_q      <= err_rx_d;
      v1_q          <= v1_d;
      v2_q          <= v2_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign err_rx      = err_rx_q;
  assign v1          = v1_q;
  assign v2          = v2_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_dda_link_host.sv
// Bench for dda_link_host: a uart model, a randomized stimulus sequence and a
// scoreboard that checks transmitted bytes and frame outcomes independently.
module tb_dda_link_host;

  localparam int TMO    = 50;
  localparam int K_DONE = 0;
  localparam int K_TMO  = 1;
  localparam int K_RXE  = 2;

  typedef struct {
    int          kind;
    logic [15:0] v1;
    logic [15:0] v2;
  } exp_t;

  logic        clk, rst, start;
  logic [15:0] ic1, ic2, vk_m, vd_m, dt;
  logic        busy, done, err_timeout, err_rx;
  logic [15:0] v1, v2;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy, rx_valid, rx_error;
  logic [7:0]  rx_data;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [15:0] par [5];
  logic [7:0]  resp [5];
  logic [7:0]  exp_tx [$];
  exp_t        exp_q [$];
  int          tx_cyc_q [$];
  logic [15:0] ref_v1 = '0;
  logic [15:0] ref_v2 = '0;
  int          busy_len = 20;
  int          bp_extra = 0;
  int          busy_cnt = 0;
  int          n_tx = 0;
  int          last_tx_cyc = 0;
  int          last_rx_cyc = 0;

  dda_link_host #(.N(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ic1(ic1), .ic2(ic2), .vK_M(vk_m), .vD_M(vd_m), .dt(dt),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_rx(err_rx),
    .v1(v1), .v2(v2), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // uart model: accepts a byte on tx_start, then reports busy for busy_len cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (n_tx > 0) chk("tx_spacing_ge3", 32'((cyc - last_tx_cyc) >= 3), 1);
        last_tx_cyc = cyc;
        tx_cyc_q.push_back(cyc);
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL tx_extra: got byte 0x%02h, expected no transmission", tx_data);
        end else begin
          chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
        end
        n_tx++;
        busy_cnt = busy_len + ((bp_extra > 0 && n_tx == 3) ? bp_extra : 0);
      end
      @(posedge clk);
      #1;
      tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
  end

  task automatic check_outcome(input int kind, input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: outcome kind %0d reported, expected none pending", name, kind);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      if (kind == K_DONE) begin
        chk({name, "_v1"}, {16'h0, v1}, {16'h0, e.v1});
        chk({name, "_v2"}, {16'h0, v2}, {16'h0, e.v2});
        ref_v1 = e.v1;
        ref_v2 = e.v2;
      end else begin
        chk({name, "_v1_kept"}, {16'h0, v1}, {16'h0, ref_v1});
        chk({name, "_v2_kept"}, {16'h0, v2}, {16'h0, ref_v2});
      end
    end
  endtask

  // Outcome monitor: pops the scoreboard whenever done or an error flag rises
  initial begin
    logic done_d1, eto_d1, erx_d1;
    done_d1 = 1'b0;
    eto_d1  = 1'b0;
    erx_d1  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_d1 = 1'b0;
        eto_d1  = 1'b0;
        erx_d1  = 1'b0;
        continue;
      end
      if (done_d1) chk("busy_low_after_done", busy, 0);
      if (done) begin
        chk("done_single_cycle", done_d1, 0);
        chk("busy_during_done", busy, 1);
        if (!done_d1) check_outcome(K_DONE, "done");
      end else begin
        chk("v1_hold", {16'h0, v1}, {16'h0, ref_v1});
        chk("v2_hold", {16'h0, v2}, {16'h0, ref_v2});
      end
      if (err_timeout && !eto_d1) begin
        check_outcome(K_TMO, "timeout");
        chk("timeout_latency", cyc - last_rx_cyc, TMO + 1);
        chk("busy_after_timeout", busy, 0);
      end
      if (err_rx && !erx_d1) begin
        check_outcome(K_RXE, "rx_error");
        chk("busy_after_rx_error", busy, 0);
      end
      done_d1 = done;
      eto_d1  = err_timeout;
      erx_d1  = err_rx;
    end
  end

  task automatic send_rx(input logic [7:0] d, input logic err);
    rx_valid    = 1'b1;
    rx_data     = d;
    rx_error    = err;
    last_rx_cyc = cyc;
    tick();
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic drive_params(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                              input logic [15:0] d, input logic [15:0] e);
    ic1 = a; ic2 = b; vk_m = c; vd_m = d; dt = e;
  endtask

  task automatic run_frame(input int mode, input bit stray, input int bp);
    exp_t e;
    int   cnt;
    n_tx = 0;
    tx_cyc_q.delete();
    bp_extra = bp;
    for (int f = 0; f < 5; f++) begin
      exp_tx.push_back(8'(par[f] / 256));
      exp_tx.push_back(8'(par[f] % 256));
    end
    e.kind = mode;
    e.v1   = 16'(resp[0] * 256 + resp[1]);
    e.v2   = 16'(resp[2] * 256 + resp[3]);
    exp_q.push_back(e);

    chk("idle_before_start", busy, 0);
    drive_params(par[0], par[1], par[2], par[3], par[4]);
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_params(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    chk("busy_after_start", busy, 1);
    chk("err_timeout_cleared", err_timeout, 0);
    chk("err_rx_cleared", err_rx, 0);

    cnt = 0;
    while (n_tx < 10 && cnt < 20000) begin
      rx_valid = stray && ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      start    = stray && ($urandom_range(0, 4) == 0);
      if (start) drive_params(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      tick();
      cnt++;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    if (n_tx < 10) begin
      chk("tx_frame_within_budget", n_tx, 10);
      finish_run();
    end

    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (tx_busy && cnt < 20000);
    @(posedge clk);
    #1;
    tick();

    if (mode == K_DONE) begin
      for (int i = 0; i < 5; i++) begin
        send_rx(resp[i], 1'b0);
        repeat ($urandom_range(0, 6)) tick();
      end
    end else if (mode == K_TMO) begin
      for (int i = 0; i < 2; i++) begin
        send_rx(resp[i], 1'b0);
        repeat ($urandom_range(0, 6)) tick();
      end
    end else begin
      send_rx(resp[0], 1'b0);
      repeat ($urandom_range(0, 6)) tick();
      send_rx(resp[1], 1'b1);
    end

    cnt = 0;
    while ((exp_q.size() != 0 || busy) && cnt < 500) begin
      tick();
      cnt++;
    end
    chk("outcome_reported", exp_q.size(), 0);
    chk("busy_low_after_frame", busy, 0);
    chk("tx_start_count", n_tx, 10);
    chk("tx_bytes_all_sent", exp_tx.size(), 0);
    chk("err_timeout_flag", err_timeout, 32'(mode == K_TMO));
    chk("err_rx_flag", err_rx, 32'(mode == K_RXE));
    if (bp > 0 && tx_cyc_q.size() >= 4)
      chk("backpressure_gap", 32'((tx_cyc_q[3] - tx_cyc_q[2]) > bp), 1);
    exp_q.delete();
    exp_tx.delete();
    tick();
  endtask

  task automatic reset_mid_frame();
    int cnt;
    n_tx = 0;
    bp_extra = 0;
    for (int f = 0; f < 5; f++) begin
      exp_tx.push_back(8'(par[f] / 256));
      exp_tx.push_back(8'(par[f] % 256));
    end
    drive_params(par[0], par[1], par[2], par[3], par[4]);
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    do begin
      @(posedge clk);
      #2;
      cnt++;
    end while (!(tx_start && n_tx == 4) && cnt < 5000);
    chk("fifth_byte_reached", n_tx, 4);
    rst = 1'b1;
    #1;
    chk("rst_async_tx_start", tx_start, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_tx_data", {24'h0, tx_data}, 0);
    chk("rst_async_done", done, 0);
    chk("rst_async_v1", {16'h0, v1}, 0);
    chk("rst_async_v2", {16'h0, v2}, 0);
    exp_tx.delete();
    exp_q.delete();
    ref_v1   = '0;
    ref_v2   = '0;
    busy_cnt = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < 5; i++) begin
      par[i]  = 16'($urandom);
      resp[i] = 8'($urandom);
    end
  endtask

  // Test sequence
  initial begin
    int mode;
    rst = 1'b1;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    rx_data = '0;
    drive_params('0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err_timeout", err_timeout, 0);
    chk("reset_err_rx", err_rx, 0);
    chk("reset_v1", {16'h0, v1}, 0);
    chk("reset_v2", {16'h0, v2}, 0);
    chk("reset_tx_start", tx_start, 0);
    chk("reset_tx_data", {24'h0, tx_data}, 0);
    rst = 1'b0;
    tick();

    // Nominal frame
    par  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0102};
    resp = '{8'h40, 8'h00, 8'hC0, 8'h00, 8'hFF};
    busy_len = 20;
    run_frame(K_DONE, 1'b0, 0);
    chk("nominal_v1", {16'h0, v1}, 32'h4000);
    chk("nominal_v2", {16'h0, v2}, 32'hC000);

    // Back-pressure before byte 3
    randomize_frame();
    run_frame(K_DONE, 1'b0, 500);

    // Timeout after two response bytes
    randomize_frame();
    run_frame(K_TMO, 1'b0, 0);

    // Receive error on byte 1, then a clean frame clears err_rx
    randomize_frame();
    run_frame(K_RXE, 1'b0, 0);
    randomize_frame();
    run_frame(K_DONE, 1'b0, 0);

    // Stray bytes and extra starts during transmission
    randomize_frame();
    run_frame(K_DONE, 1'b1, 0);

    // Reset mid-frame, then a full frame from byte 0
    randomize_frame();
    reset_mid_frame();
    randomize_frame();
    run_frame(K_DONE, 1'b0, 0);

    // Randomized frames
    for (int i = 0; i < 8; i++) begin
      randomize_frame();
      busy_len = $urandom_range(0, 20);
      mode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : K_DONE;
      run_frame(mode, 1'($urandom_range(0, 1)), 0);
    end

    finish_run();
  end

endmodule
